// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the core load/store
// port and a debug/loader port, with debug bus lock, starvation override and OOB guard.
module dmem_arbiter #(
    parameter int XLEN         = 32,
    parameter int NWORDS       = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [XLEN-1:0] c_addr,
    input  logic [XLEN-1:0] c_wdata,
    output logic            c_gnt,
    output logic [XLEN-1:0] c_rdata,
    output logic            core_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic            d_lock,
    output logic            d_gnt,
    output logic [XLEN-1:0] d_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            oob_err
);

    localparam logic [3:0]      LIMIT      = 4'(STARVE_LIMIT);
    localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(NWORDS);

    logic            last;     // 0 = core, 1 = debug
    logic            locked;
    logic [3:0]      starve;

    logic            starve_win;
    logic            core_win;
    logic            dbg_win;
    logic            any_gnt;
    logic            oob;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic            sel_we;

    assign starve_win = c_req && (starve == LIMIT);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        core_win = 1'b0;
        dbg_win  = 1'b0;
        if (reset) begin
            if (starve_win) begin
                core_win = 1'b1;
            end else if (locked && d_req) begin
                dbg_win = 1'b1;
            end else if (c_req && d_req) begin
                core_win = last;
                dbg_win  = ~last;
            end else begin
                core_win = c_req;
                dbg_win  = d_req;
            end
        end
    end

    assign any_gnt = core_win | dbg_win;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (core_win) begin
            sel_addr  = c_addr;
            sel_wdata = c_wdata;
            sel_we    = c_we;
        end else if (dbg_win) begin
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
            sel_we    = d_we;
        end
    end

    // Out-of-range accesses are still granted so the requester never hangs.
    assign oob = any_gnt && (sel_addr[XLEN-1:2] >= WORD_LIMIT);

    assign mem_addr   = sel_addr;
    assign mem_wdata  = sel_wdata;
    assign mem_we     = sel_we & ~oob;
    assign c_gnt      = core_win;
    assign d_gnt      = dbg_win;
    assign core_stall = c_req & ~core_win;
    assign c_rdata    = (core_win && !oob) ? mem_rdata : '0;
    assign d_rdata    = (dbg_win  && !oob) ? mem_rdata : '0;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last    <= 1'b1;
            locked  <= 1'b0;
            starve  <= '0;
            oob_err <= 1'b0;
        end else begin
            if (any_gnt) begin
                last <= dbg_win;
            end

            // A starvation override leaves the lock alone; only a debug access or idle debug changes it.
            if (!d_req) begin
                locked <= 1'b0;
            end else if (dbg_win) begin
                locked <= d_lock;
            end

            if (c_req && !core_win) begin
                starve <= (starve == LIMIT) ? starve : starve + 4'd1;
            end else begin
                starve <= '0;
            end

            if (oob) begin
                oob_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a word-addressed memory model behind the port,
// expectations queued per cycle and compared at the falling edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, d_gnt, core_stall, mem_we, oob_err;
    logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic        c_gnt;
        logic        d_gnt;
        logic        stall;
        logic        we;
        logic        oob;
        logic [31:0] c_rdata;
        logic [31:0] d_rdata;
    } exp_t;

    exp_t sb[$];

    logic [31:0] mem [0:1023];

    dmem_arbiter #(
        .XLEN        (32),
        .NWORDS      (1024),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rdata   (c_rdata),
        .core_stall(core_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_lock    (d_lock),
        .d_gnt     (d_gnt),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .oob_err   (oob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: out-of-range addresses return junk the arbiter must hide.
    assign mem_rdata = (mem_addr < 32'h1000) ? mem[mem_addr[11:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'h1000) mem[mem_addr[11:2]] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the rising edge, queue the expectation, compare at the falling edge.
    task automatic step(input string tag, input logic rst, input logic cr, input logic cw,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                        input logic dl,
                        input logic e_cg, input logic e_dg, input logic e_st, input logic e_we,
                        input logic e_oob, input logic [31:0] e_cr, input logic [31:0] e_dr);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = dl;
        e.tag = tag; e.c_gnt = e_cg; e.d_gnt = e_dg; e.stall = e_st; e.we = e_we;
        e.oob = e_oob; e.c_rdata = e_cr; e.d_rdata = e_dr;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check($sformatf("%s.c_gnt", e.tag),      32'(c_gnt),      32'(e.c_gnt));
        check($sformatf("%s.d_gnt", e.tag),      32'(d_gnt),      32'(e.d_gnt));
        check($sformatf("%s.core_stall", e.tag), 32'(core_stall), 32'(e.stall));
        check($sformatf("%s.mem_we", e.tag),     32'(mem_we),     32'(e.we));
        check($sformatf("%s.oob_err", e.tag),    32'(oob_err),    32'(e.oob));
        check($sformatf("%s.c_rdata", e.tag),    c_rdata,         e.c_rdata);
        check($sformatf("%s.d_rdata", e.tag),    d_rdata,         e.d_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        reset = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;

        //    tag        rst cr cw c_addr  c_wdata       dr dw d_addr   d_wdata       dl  cg dg st we oob c_rdata       d_rdata
        step("rst_hold", 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0,        0,  0, 0, 1, 0, 0, 32'h0,        32'h0);
        step("core_wr",  1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0,        0,  1, 0, 0, 1, 0, 32'hA5000004, 32'h0);
        step("core_rd",  1, 1, 0, 32'h10, 32'h0,        0, 0, 32'h0,   32'h0,        0,  1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
        step("rst2",     0, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,   32'h0,        0,  0, 0, 0, 0, 0, 32'h0,        32'h0);
        // Contention straight after reset alternates, core first.
        step("rr1",      1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h14,  32'h0,        0,  1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
        step("rr2",      1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h14,  32'h0,        0,  0, 1, 1, 0, 0, 32'h0,        32'hA5000005);
        step("rr3",      1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h14,  32'h0,        0,  1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
        step("rr4",      1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h14,  32'h0,        0,  0, 1, 1, 0, 0, 32'h0,        32'hA5000005);
        step("core_wr2", 1, 1, 1, 32'h20, 32'h12345678, 0, 0, 32'h0,   32'h0,        0,  1, 0, 0, 1, 0, 32'hA5000008, 32'h0);
        // Locked debug starves the core for exactly four cycles.
        step("lock1",    1, 1, 0, 32'h20, 32'h0,        1, 1, 32'h24,  32'hCAFE0001, 1,  0, 1, 1, 1, 0, 32'h0,        32'hA5000009);
        step("lock2",    1, 1, 0, 32'h20, 32'h0,        1, 1, 32'h24,  32'hCAFE0001, 1,  0, 1, 1, 1, 0, 32'h0,        32'hCAFE0001);
        step("lock3",    1, 1, 0, 32'h20, 32'h0,        1, 1, 32'h24,  32'hCAFE0001, 1,  0, 1, 1, 1, 0, 32'h0,        32'hCAFE0001);
        step("lock4",    1, 1, 0, 32'h20, 32'h0,        1, 1, 32'h24,  32'hCAFE0001, 1,  0, 1, 1, 1, 0, 32'h0,        32'hCAFE0001);
        step("starve",   1, 1, 0, 32'h20, 32'h0,        1, 1, 32'h24,  32'hCAFE0001, 1,  1, 0, 0, 0, 0, 32'h12345678, 32'h0);
        step("lock_kept",1, 1, 0, 32'h20, 32'h0,        1, 1, 32'h24,  32'hCAFE0001, 1,  0, 1, 1, 1, 0, 32'h0,        32'hCAFE0001);
        // Debug idles one cycle while locked: the core takes it and the lock is gone.
        step("rel_idle", 1, 1, 0, 32'h20, 32'h0,        0, 0, 32'h24,  32'h0,        0,  1, 0, 0, 0, 0, 32'h12345678, 32'h0);
        step("rel_rr1",  1, 1, 0, 32'h20, 32'h0,        1, 0, 32'h24,  32'h0,        0,  0, 1, 1, 0, 0, 32'h0,        32'hCAFE0001);
        step("rel_rr2",  1, 1, 0, 32'h20, 32'h0,        1, 0, 32'h24,  32'h0,        0,  1, 0, 0, 0, 0, 32'h12345678, 32'h0);
        step("relock",   1, 0, 0, 32'h0,  32'h0,        1, 0, 32'h24,  32'h0,        1,  0, 1, 0, 0, 0, 32'h0,        32'hCAFE0001);
        step("all_idle", 1, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,   32'h0,        0,  0, 0, 0, 0, 0, 32'h0,        32'h0);
        step("unlocked", 1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h24,  32'h0,        0,  1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
        // Last in-range word, then the first out-of-range word.
        step("top_wr",   1, 0, 0, 32'h0,  32'h0,        1, 1, 32'hFFC, 32'h0BADF00D, 0,  0, 1, 0, 1, 0, 32'h0,        32'hA50003FF);
        step("oob_wr",   1, 0, 0, 32'h0,  32'h0,        1, 1, 32'h1000,32'h00000055, 0,  0, 1, 0, 0, 0, 32'h0,        32'h0);
        step("top_rd",   1, 0, 0, 32'h0,  32'h0,        1, 0, 32'hFFC, 32'h0,        0,  0, 1, 0, 0, 1, 32'h0,        32'h0BADF00D);
        step("oob_stick",1, 1, 0, 32'h10, 32'h0,        0, 0, 32'h0,   32'h0,        0,  1, 0, 0, 0, 1, 32'hDEADBEEF, 32'h0);
        // Reset in the middle of a lock: grants drop at once, core wins the next contention.
        step("mid_lock", 1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h24,  32'h0,        1,  0, 1, 1, 0, 1, 32'h0,        32'hCAFE0001);
        step("mid_rst",  0, 1, 0, 32'h10, 32'h0,        1, 0, 32'h24,  32'h0,        1,  0, 0, 1, 0, 0, 32'h0,        32'h0);
        step("post_rst", 1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h24,  32'h0,        1,  1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the datapath's load/store port and a debug/loader port, such as a program loader or JTAG-style memory poker. It sits between the datapath and the address decoder that feeds `dmem` and the console/test-status registers. Arbitration is round-robin with an optional debug bus lock, and a starvation limit guarantees the core forward progress. Out-of-range accesses are blocked and recorded in a sticky error flag.

## Interface

Parameters:
- `XLEN`, 32: data/address width.
- `NWORDS`, 1024: dmem depth in words; word index is `addr[XLEN-1:2]`.
- `STARVE_LIMIT`, 4: consecutive denied core cycles before the core is forced to win; range 1..15.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  core access request.
- `c_we`  in  1  core write enable.
- `c_addr`  in  XLEN  core byte address.
- `c_wdata`  in  XLEN  core write data.
- `c_gnt`  out  1  core access performed this cycle.
- `c_rdata`  out  XLEN  core read data; valid while `c_gnt` is high, otherwise 0.
- `core_stall`  out  1  `c_req & ~c_gnt`; routed to the datapath pipeline hold.
- `d_req`, `d_we`, `d_addr`, `d_wdata`  in  1/1/XLEN/XLEN  debug request fields.
- `d_lock`  in  1  debug requests to keep ownership after this access.
- `d_gnt`  out  1  debug access performed this cycle.
- `d_rdata`  out  XLEN  debug read data; valid while `d_gnt` is high, otherwise 0.
- `mem_addr`, `mem_wdata`  out  XLEN  to the memory/IO decoder.
- `mem_we`  out  1  to the memory/IO decoder.
- `mem_rdata`  in  XLEN  combinational read data from the decoder.
- `oob_err`  out  1  sticky out-of-range flag.

## Operation

- State registers:
  - `last` (0 = core, 1 = debug).
  - `locked`.
  - `starve` (4 bits).
  - `oob_err`.
- Winner selection is combinational each cycle, from the request inputs and the registers, in this priority order:
  1. `c_req` and `starve == STARVE_LIMIT`: the core wins. This overrides the lock.
  2. `locked` and `d_req`: debug wins.
  3. Both requesting: the port that is not `last` wins.
  4. Exactly one requesting: that port wins.
  5. Neither requesting: no grant.
- The granted port's `addr`/`wdata`/`we` drive `mem_*`. With no grant, `mem_addr = 0`, `mem_wdata = 0`, `mem_we = 0`.
- Read data is routed from `mem_rdata` to the granted port only.
- Out-of-range access: the granted access has `addr[XLEN-1:2] >= NWORDS`.
  - `mem_we` is forced to 0 and the port's rdata reads 0.
  - The grant is still given, so the requester is not hung.
  - `oob_err` is set at the next edge and cleared only by reset.
- `last` updates on every grant to the winning port and holds when there is no grant.
- `locked` updates as follows:
  - Set at the edge ending a debug grant with `d_lock = 1`.
  - Cleared at the edge ending a debug grant with `d_lock = 0`.
  - Cleared at any edge where `d_req = 0`.
  - Unchanged when the core wins by starvation override.
- `starve` updates as follows:
  - Increments, saturating at `STARVE_LIMIT`, on each edge where `c_req & ~c_gnt`.
  - Resets to 0 on `c_gnt` or `~c_req`.

## Timing

- Zero-cycle grant: a request is granted in the same cycle it is presented. The write commits at the rising edge ending the grant cycle, and read data is valid in the grant cycle.
- A requester must hold `req` and all its fields stable until it sees `gnt`.
- Reset asserted (`reset = 0`):
  - Registers clear immediately: `last = 1`, so the core wins the first contention; `locked = 0`; `starve = 0`; `oob_err = 0`.
  - `c_gnt`, `d_gnt` and `mem_we` are forced to 0, and `mem_*`/`rdata` outputs read 0.
  - `core_stall` equals `c_req`.
- Reset deasserting between edges: normal arbitration resumes the same cycle. Any in-flight lock is lost.
- Worst-case core latency: `STARVE_LIMIT` cycles of stall under a continuous debug lock.
- Worst-case debug latency: 1 cycle when the core requests continuously and debug is unlocked.

## Test plan

- Core alone: `c_req = 1`, `c_we = 1`, `c_addr = 0x10`, `c_wdata = 0xDEADBEEF`, then a read of `0x10` -> `c_gnt = 1` both cycles, `core_stall = 0`, read returns `0xDEADBEEF`.
- Contention after reset: both request continuously for 4 cycles, `d_lock = 0` -> grants alternate core, debug, core, debug; `core_stall` is high on cycles 2 and 4.
- Lock plus starvation with `STARVE_LIMIT = 4`: debug holds `d_req = 1` and `d_lock = 1`, core requests from cycle 1 -> debug is granted cycles 1–4, core is granted cycle 5, debug is granted cycle 6 (lock retained).
- Lock release: debug drops `d_req` for one cycle while locked, then both request -> the core is granted the idle cycle if it requests, and `locked = 0` afterwards, so round-robin resumes.
- Out of range with `NWORDS = 1024`: debug writes `d_addr = 0x1000` -> `d_gnt = 1`, `mem_we = 0`, `oob_err = 1` from the next edge and stays 1 until `reset` pulses low.
- Mid-lock reset: assert `reset = 0` while debug is locked and both ports request -> grants go to 0 immediately; after release the core wins the first contention.
